// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, req/ack fetch to instruction memory, IF/ID register,
// one-entry skid buffer for decode freezes, and branch redirect with wrong-path drop.
module fetch_unit #(
  parameter int                     ADDRESS_LEN = 32,
  parameter logic [ADDRESS_LEN-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [ADDRESS_LEN-1:0] branch_addr,
  output logic                   imem_req,
  output logic [ADDRESS_LEN-1:0] imem_addr,
  input  logic                   imem_ack,
  input  logic [ADDRESS_LEN-1:0] imem_rdata,
  output logic [ADDRESS_LEN-1:0] pc,
  output logic [ADDRESS_LEN-1:0] instruction,
  output logic                   valid
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t                 state_reg, state_next;
  logic [ADDRESS_LEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDRESS_LEN-1:0] skid_instr_reg, skid_instr_next;
  logic [ADDRESS_LEN-1:0] skid_pc_reg, skid_pc_next;
  logic                   drop_reg, drop_next;
  logic [ADDRESS_LEN-1:0] redirect_pc_reg, redirect_pc_next;
  logic [ADDRESS_LEN-1:0] pc_reg, pc_next;
  logic [ADDRESS_LEN-1:0] instr_reg, instr_next;
  logic                   valid_reg, valid_next;
  logic [ADDRESS_LEN-1:0] fetch_pc_plus4;

  assign fetch_pc_plus4 = fetch_pc_reg + ADDRESS_LEN'(4);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= RUN;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (branch_taken)
      state_next = RUN;
    else if (state_reg == RUN && imem_ack && !drop_reg && freeze)
      state_next = STALL;
    else if (state_reg == STALL && !freeze)
      state_next = RUN;
  end

  always_comb begin
    imem_req  = !rst && (state_reg == RUN);
    imem_addr = fetch_pc_reg;
  end

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    skid_instr_next  = skid_instr_reg;
    skid_pc_next     = skid_pc_reg;
    drop_next        = drop_reg;
    redirect_pc_next = redirect_pc_reg;
    pc_next          = pc_reg;
    instr_next       = instr_reg;
    valid_next       = valid_reg;
    if (branch_taken) begin
      pc_next         = '0;
      instr_next      = '0;
      valid_next      = 1'b0;
      skid_instr_next = '0;
      skid_pc_next    = '0;
      // An unacked request must complete at its original address; remember the target.
      if (state_reg == RUN && !imem_ack) begin
        drop_next        = 1'b1;
        redirect_pc_next = branch_addr;
      end else begin
        fetch_pc_next = branch_addr;
        drop_next     = 1'b0;
      end
    end else if (state_reg == RUN) begin
      if (imem_ack) begin
        if (drop_reg) begin
          fetch_pc_next = redirect_pc_reg;
          drop_next     = 1'b0;
          if (!freeze) valid_next = 1'b0;
        end else begin
          fetch_pc_next = fetch_pc_plus4;
          if (freeze) begin
            skid_instr_next = imem_rdata;
            skid_pc_next    = fetch_pc_plus4;
          end else begin
            instr_next = imem_rdata;
            pc_next    = fetch_pc_plus4;
            valid_next = 1'b1;
          end
        end
      end else if (!freeze) begin
        valid_next = 1'b0;
      end
    end else if (!freeze) begin
      instr_next = skid_instr_reg;
      pc_next    = skid_pc_reg;
      valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      skid_instr_reg  <= '0;
      skid_pc_reg     <= '0;
      drop_reg        <= 1'b0;
      redirect_pc_reg <= '0;
      pc_reg          <= '0;
      instr_reg       <= '0;
      valid_reg       <= 1'b0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      skid_instr_reg  <= skid_instr_next;
      skid_pc_reg     <= skid_pc_next;
      drop_reg        <= drop_next;
      redirect_pc_reg <= redirect_pc_next;
      pc_reg          <= pc_next;
      instr_reg       <= instr_next;
      valid_reg       <= valid_next;
    end
  end

  assign pc          = pc_reg;
  assign instruction = instr_reg;
  assign valid       = valid_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed cycle-by-cycle vectors for fetch_unit; memory returns word = address.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] pc, instruction;
  logic        valid;

  logic        w_req;
  logic [31:0] w_addr, w_pc, w_instr;
  logic        w_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr;

  fetch_unit #(.ADDRESS_LEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc),
    .instruction(instruction), .valid(valid)
  );

  // Zero-wait memory on a second instance to exercise PC wraparound.
  fetch_unit #(.ADDRESS_LEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .freeze(1'b0), .branch_taken(1'b0),
    .branch_addr(32'h0), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_req), .imem_rdata(w_addr), .pc(w_pc),
    .instruction(w_instr), .valid(w_valid)
  );

  typedef struct {
    logic        rst, frz, br;
    logic [31:0] baddr;
    logic        ack;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc, exp_instr;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  function automatic vec_t mk(logic r, logic f, logic b, logic [31:0] ba, logic a,
                              logic eq, logic [31:0] ea, logic ev,
                              logic [31:0] ep, logic [31:0] ei);
    vec_t v;
    v.rst = r; v.frz = f; v.br = b; v.baddr = ba; v.ack = a;
    v.exp_req = eq; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep; v.exp_instr = ei;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    //            rst frz br baddr     ack  req addr      vld pc        instr
    vecs[0]  = mk(1, 0, 0, 32'h0,   0,   0, 32'h0,   0, 32'h0,   32'h0);
    vecs[1]  = mk(0, 0, 0, 32'h0,   1,   1, 32'h0,   1, 32'h4,   32'h0);
    vecs[2]  = mk(0, 0, 0, 32'h0,   1,   1, 32'h4,   1, 32'h8,   32'h4);
    vecs[3]  = mk(0, 0, 0, 32'h0,   1,   1, 32'h8,   1, 32'hc,   32'h8);
    vecs[4]  = mk(0, 0, 0, 32'h0,   1,   1, 32'hc,   1, 32'h10,  32'hc);
    vecs[5]  = mk(0, 1, 0, 32'h0,   1,   1, 32'h10,  1, 32'h10,  32'hc);
    vecs[6]  = mk(0, 1, 0, 32'h0,   0,   0, 32'h14,  1, 32'h10,  32'hc);
    vecs[7]  = mk(0, 1, 0, 32'h0,   0,   0, 32'h14,  1, 32'h10,  32'hc);
    vecs[8]  = mk(0, 0, 0, 32'h0,   0,   0, 32'h14,  1, 32'h14,  32'h10);
    vecs[9]  = mk(0, 0, 0, 32'h0,   1,   1, 32'h14,  1, 32'h18,  32'h14);
    vecs[10] = mk(0, 0, 0, 32'h0,   0,   1, 32'h18,  0, 32'h18,  32'h14);
    vecs[11] = mk(0, 0, 0, 32'h0,   0,   1, 32'h18,  0, 32'h18,  32'h14);
    vecs[12] = mk(0, 0, 0, 32'h0,   1,   1, 32'h18,  1, 32'h1c,  32'h18);
    vecs[13] = mk(0, 0, 0, 32'h0,   1,   1, 32'h1c,  1, 32'h20,  32'h1c);
    vecs[14] = mk(0, 0, 1, 32'h100, 0,   1, 32'h20,  0, 32'h0,   32'h0);
    vecs[15] = mk(0, 0, 0, 32'h0,   1,   1, 32'h20,  0, 32'h0,   32'h0);
    vecs[16] = mk(0, 0, 0, 32'h0,   1,   1, 32'h100, 1, 32'h104, 32'h100);
    vecs[17] = mk(0, 1, 0, 32'h0,   1,   1, 32'h104, 1, 32'h104, 32'h100);
    vecs[18] = mk(0, 1, 1, 32'h200, 0,   0, 32'h108, 0, 32'h0,   32'h0);
    vecs[19] = mk(0, 0, 0, 32'h0,   1,   1, 32'h200, 1, 32'h204, 32'h200);
    vecs[20] = mk(0, 0, 1, 32'h300, 1,   1, 32'h204, 0, 32'h0,   32'h0);
    vecs[21] = mk(0, 0, 0, 32'h0,   1,   1, 32'h300, 1, 32'h304, 32'h300);
    vecs[22] = mk(0, 0, 1, 32'h400, 0,   1, 32'h304, 0, 32'h0,   32'h0);
    vecs[23] = mk(0, 0, 1, 32'h500, 0,   1, 32'h304, 0, 32'h0,   32'h0);
    vecs[24] = mk(0, 0, 0, 32'h0,   1,   1, 32'h304, 0, 32'h0,   32'h0);
    vecs[25] = mk(0, 0, 0, 32'h0,   1,   1, 32'h500, 1, 32'h504, 32'h500);
    vecs[26] = mk(0, 1, 0, 32'h0,   0,   1, 32'h504, 1, 32'h504, 32'h500);
    vecs[27] = mk(0, 0, 0, 32'h0,   0,   1, 32'h504, 0, 32'h504, 32'h500);
    vecs[28] = mk(1, 0, 0, 32'h0,   0,   0, 32'h504, 0, 32'h0,   32'h0);
    vecs[29] = mk(0, 0, 0, 32'h0,   1,   1, 32'h0,   1, 32'h4,   32'h0);

    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst          = vecs[i].rst;
      freeze       = vecs[i].frz;
      branch_taken = vecs[i].br;
      branch_addr  = vecs[i].baddr;
      imem_ack     = vecs[i].ack;
      #1;
      chk("imem_req", i, {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
      chk("imem_addr", i, imem_addr, vecs[i].exp_addr);
      @(posedge clk);
      #1;
      chk("valid", i, {31'b0, valid}, {31'b0, vecs[i].exp_valid});
      chk("pc", i, pc, vecs[i].exp_pc);
      chk("instruction", i, instruction, vecs[i].exp_instr);
      $display("vec %0d: req=%0b addr=%h ack=%0b -> valid=%0b pc=%h instr=%h",
               i, vecs[i].exp_req, imem_addr, vecs[i].ack, valid, pc, instruction);
    end

    // Wraparound from RESET_PC = 0xFFFFFFFC.
    @(negedge clk);
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("wrap_req", 0, {31'b0, w_req}, 32'h1);
    chk("wrap_addr0", 0, w_addr, 32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    chk("wrap_valid", 0, {31'b0, w_valid}, 32'h1);
    chk("wrap_pc", 0, w_pc, 32'h0);
    chk("wrap_instr", 0, w_instr, 32'hFFFF_FFFC);
    @(negedge clk);
    #1;
    chk("wrap_addr1", 1, w_addr, 32'h0);
    $display("wrap: valid=%0b pc=%h instr=%h next_addr=%h", w_valid, w_pc, w_instr, w_addr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage with IF/ID pipeline register. Holds the program counter and issues word fetches to a variable-latency instruction memory over a req/ack handshake. Delivers instruction plus PC+4 to the decode stage. Honours the decode-stage hazard freeze with a one-entry skid buffer, and redirects on taken branches from the execute stage, discarding any wrong-path fetch in flight.

## Interface
- `ADDRESS_LEN`, 32, width of addresses, PC and instruction words.
- `RESET_PC`, 0, first fetch address after reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `freeze`  in  1  hazard from decode; when 1, the IF/ID register holds.
- `branch_taken`  in  1  redirect request from execute, single-cycle pulse.
- `branch_addr`  in  ADDRESS_LEN  redirect target; valid while `branch_taken`=1.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  ADDRESS_LEN  fetch address; stable while `imem_req`=1 and no ack.
- `imem_ack`  in  1  data valid for the current request; may be in the same cycle as `imem_req`.
- `imem_rdata`  in  ADDRESS_LEN  fetched word; sampled only when `imem_ack`=1.
- `pc`  out  ADDRESS_LEN  registered: fetch address + 4 of the delivered instruction.
- `instruction`  out  ADDRESS_LEN  registered: delivered instruction word.
- `valid`  out  1  registered: `instruction` and `pc` are real (not a bubble).

## Operation
State:
- `fetch_pc`
- FSM state: RUN or STALL
- skid buffer: `skid_instr`, `skid_pc`
- `drop`: a wrong-path fetch is outstanding
- `redirect_pc`

RUN (`imem_req`=1, `imem_addr`=`fetch_pc`):
- ack, no branch, freeze=0: IF/ID <= {rdata, fetch_pc+4, valid=1}; fetch_pc += 4.
- ack, no branch, freeze=1: skid <= {rdata, fetch_pc+4}; fetch_pc += 4; go to STALL; IF/ID holds.
- no ack, freeze=0: valid <= 0 (bubble); `instruction` and `pc` hold their values.
- no ack, freeze=1: IF/ID holds.
- ack while `drop`=1: discard rdata; fetch_pc <= redirect_pc; drop <= 0; IF/ID valid <= 0 unless freeze=1.

STALL (`imem_req`=0):
- freeze=1: hold.
- freeze=0: IF/ID <= skid with valid=1; go to RUN.

`branch_taken`=1 has highest priority and overrides the freeze for IF/ID:
- IF/ID <= {instruction=0, pc=0, valid=0}; skid discarded; state <= RUN.
- If in RUN with no ack this cycle (request outstanding): keep `imem_addr` unchanged; drop <= 1; redirect_pc <= branch_addr.
- Otherwise (ack this cycle, or in STALL): any ack data is discarded; fetch_pc <= branch_addr; drop <= 0.
- Branch while drop=1 and no ack: redirect_pc <= new branch_addr (latest wins).

Arithmetic:
- PC increments are modulo 2^ADDRESS_LEN; 0xFFFFFFFC+4 wraps to 0.
- Addresses are not checked for alignment.

## Timing
- Reset values: `pc`=0, `instruction`=0, `valid`=0, `fetch_pc`=RESET_PC, state=RUN, drop=0, skid=0.
- `imem_req`=0 while `rst`=1.
- Reset mid-fetch abandons the request; the memory must tolerate the dropped request.
- `imem_req` and `imem_addr` are combinational from state. The first request goes out in the first cycle with `rst`=0.
- Latency: ack in cycle N gives `valid`/`instruction`/`pc` updated at the edge ending cycle N.
- Zero-wait memory (ack same cycle as req) sustains 1 instruction/cycle.
- Freeze release from STALL: skid instruction appears at the next edge; the next request issues one cycle after release (one bubble).
- Branch penalty with zero-wait memory: 1 cycle. Target word delivered at the edge ending the cycle after `branch_taken`.
- With an outstanding slow fetch: penalty is the remaining ack wait plus one target fetch.
- `freeze` and `branch_taken` in the same cycle: the branch wins.

## Test plan
- Zero-wait memory returning word=addr, 4 cycles after reset, RESET_PC=0 -> `valid`=1 with `pc`=4,8,12,16 and `instruction`=0,4,8,12 on consecutive edges.
- 3-cycle ack latency -> `valid` pattern 0,0,1 repeating; each `instruction` matches its address; `imem_addr` stable until ack.
- `freeze` held 3 cycles coinciding with an ack for addr 0x10:
  - IF/ID holds through the freeze; `imem_req`=0 in STALL.
  - After release: `instruction`=0x10, `pc`=0x14.
  - Next request goes to 0x14.
- `branch_taken` to 0x100 while a 2-cycle fetch of 0x20 is outstanding:
  - `imem_addr` stays 0x20 until ack; that data is never delivered.
  - Next `imem_addr`=0x100; first valid `pc`=0x104.
- `branch_taken`+`freeze` together while in STALL -> skid dropped, `valid`=0, next fetch at target.
- Wrap and reset checks:
  - RESET_PC=0xFFFFFFFC: `pc`=0 for the first instruction, next `imem_addr`=0.
  - `rst` asserted mid-fetch: all outputs return to reset values next edge.
